// File: rtl/note_player_pkg.sv
// Shared types, sizes and the note-to-phase-step table for the note player.
package note_player_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } state_t;

    localparam int PHASE_W     = 20;
    localparam int SAMPLE_W    = 16;
    localparam int SAMPLE_RATE = 48000;
    localparam int STEP_W      = 20;

    // Phase increment per output sample for each note index, scaled for a
    // 2^20 phase wheel at SAMPLE_RATE. Note 49 is A4 (440 Hz), 0 is a rest.
    function automatic logic [STEP_W-1:0] note_step(input logic [5:0] note);
        logic [STEP_W-1:0] s;
        s = '0;
        case (note)
            6'd0:  s = 20'd0;
            6'd1:  s = 20'd601;
            6'd2:  s = 20'd636;
            6'd3:  s = 20'd674;
            6'd4:  s = 20'd714;
            6'd5:  s = 20'd757;
            6'd6:  s = 20'd802;
            6'd7:  s = 20'd850;
            6'd8:  s = 20'd900;
            6'd9:  s = 20'd954;
            6'd10: s = 20'd1010;
            6'd11: s = 20'd1070;
            6'd12: s = 20'd1134;
            6'd13: s = 20'd1201;
            6'd14: s = 20'd1273;
            6'd15: s = 20'd1349;
            6'd16: s = 20'd1429;
            6'd17: s = 20'd1514;
            6'd18: s = 20'd1604;
            6'd19: s = 20'd1699;
            6'd20: s = 20'd1800;
            6'd21: s = 20'd1907;
            6'd22: s = 20'd2021;
            6'd23: s = 20'd2141;
            6'd24: s = 20'd2268;
            6'd25: s = 20'd2403;
            6'd26: s = 20'd2546;
            6'd27: s = 20'd2697;
            6'd28: s = 20'd2858;
            6'd29: s = 20'd3028;
            6'd30: s = 20'd3208;
            6'd31: s = 20'd3398;
            6'd32: s = 20'd3600;
            6'd33: s = 20'd3815;
            6'd34: s = 20'd4041;
            6'd35: s = 20'd4282;
            6'd36: s = 20'd4536;
            6'd37: s = 20'd4806;
            6'd38: s = 20'd5092;
            6'd39: s = 20'd5395;
            6'd40: s = 20'd5715;
            6'd41: s = 20'd6055;
            6'd42: s = 20'd6415;
            6'd43: s = 20'd6797;
            6'd44: s = 20'd7201;
            6'd45: s = 20'd7629;
            6'd46: s = 20'd8083;
            6'd47: s = 20'd8563;
            6'd48: s = 20'd9072;
            6'd49: s = 20'd9612;
            6'd50: s = 20'd10184;
            6'd51: s = 20'd10789;
            6'd52: s = 20'd11431;
            6'd53: s = 20'd12110;
            6'd54: s = 20'd12830;
            6'd55: s = 20'd13593;
            6'd56: s = 20'd14402;
            6'd57: s = 20'd15258;
            6'd58: s = 20'd16165;
            6'd59: s = 20'd17127;
            6'd60: s = 20'd18145;
            6'd61: s = 20'd19224;
            6'd62: s = 20'd20367;
            6'd63: s = 20'd21578;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/note_step_rom.sv
// Combinational lookup from note index to phase-accumulator step.
module note_step_rom
    import note_player_pkg::*;
(
    input  logic [5:0]        note,
    output logic [STEP_W-1:0] step
);

    // Pure table lookup; no state.
    always_comb begin
        step = note_step(note);
    end

endmodule

// File: rtl/note_player.sv
// Plays one note at a time: counts beats for its duration and produces
// triangle-wave samples on request, then tells the song reader it is done.
module note_player
    import note_player_pkg::*;
#(
    parameter int PHASE_W  = note_player_pkg::PHASE_W,
    parameter int SAMPLE_W = note_player_pkg::SAMPLE_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       play_enable,
    input  logic [5:0]                 note_to_load,
    input  logic [5:0]                 duration_to_load,
    input  logic                       load_new_note,
    input  logic                       beat,
    input  logic                       generate_next_sample,
    output logic                       done_with_note,
    output logic                       new_sample_ready,
    output logic signed [SAMPLE_W-1:0] sample_out
);

    state_t              state, state_next;
    logic [5:0]          note_r, note_next;
    logic [5:0]          beats_left, beats_next;
    logic [PHASE_W-1:0]  phase, phase_next;
    logic [PHASE_W-1:0]  step, step_next;
    logic                done_next;
    logic                ready_next;
    logic [SAMPLE_W-1:0] sample_next;

    logic [STEP_W-1:0]   rom_step;
    logic [SAMPLE_W-2:0] tri_mag;
    logic [SAMPLE_W-1:0] tri_sample;
    logic                sounding;

    note_step_rom u_step_rom (
        .note (note_to_load),
        .step (rom_step)
    );

    // Fold the top phase bit into a rising/falling ramp and recentre it around zero.
    always_comb begin
        tri_mag    = phase[PHASE_W-1] ? ~phase[PHASE_W-2 -: SAMPLE_W-1]
                                      :  phase[PHASE_W-2 -: SAMPLE_W-1];
        tri_sample = {tri_mag, 1'b0} - {1'b1, {(SAMPLE_W-1){1'b0}}};
    end

    // Next-state and output decisions: sample from the current note first, then let a load override the note registers.
    always_comb begin
        state_next  = state;
        note_next   = note_r;
        beats_next  = beats_left;
        phase_next  = phase;
        step_next   = step;
        done_next   = 1'b0;
        ready_next  = generate_next_sample;
        sample_next = sample_out;
        sounding    = (state == PLAYING) && play_enable && (note_r != 6'd0);

        if (generate_next_sample) begin
            if (sounding) begin
                sample_next = tri_sample;
                phase_next  = phase + step;
            end else begin
                sample_next = '0;
            end
        end

        if (load_new_note) begin
            note_next  = note_to_load;
            beats_next = duration_to_load;
            phase_next = '0;
            step_next  = PHASE_W'(rom_step);
            state_next = PLAYING;
        end else if (state == PLAYING) begin
            if (beats_left == 6'd0) begin
                done_next  = 1'b1;
                state_next = IDLE;
            end else if (play_enable && beat) begin
                if (beats_left == 6'd1) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    beats_next = beats_left - 6'd1;
                end
            end
        end
    end

    // State, note registers and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            note_r           <= '0;
            beats_left       <= '0;
            phase            <= '0;
            step             <= '0;
            done_with_note   <= 1'b0;
            new_sample_ready <= 1'b0;
            sample_out       <= '0;
        end else begin
            state            <= state_next;
            note_r           <= note_next;
            beats_left       <= beats_next;
            phase            <= phase_next;
            step             <= step_next;
            done_with_note   <= done_next;
            new_sample_ready <= ready_next;
            sample_out       <= sample_next;
        end
    end

endmodule

// File: doc/note_player.md
# note_player

Consumes the note stream from `song_reader` and turns each note into a timed run of audio samples. On `load_new_note` it latches a 6-bit note and a 6-bit duration, then counts `beat` ticks. Between beats it synthesizes a signed 16-bit triangle wave with a phase accumulator on each `generate_next_sample` request. When the duration expires it pulses `done_with_note` back to `song_reader`, which issues the next note.

## Interface
Parameters:
- `PHASE_W`, default 20: phase accumulator width.
- `SAMPLE_W`, default 16: output sample width, two's complement.

Ports:
- `clk`  in  1: system clock. One clock domain.
- `reset`  in  1: synchronous, active-high reset.
- `play_enable`  in  1: 1 = run; 0 = pause.
- `note_to_load`  in  6: note index. 0 = rest; 1..63 = semitones, with 49 = A4 = 440 Hz.
- `duration_to_load`  in  6: note length in beats.
- `load_new_note`  in  1: one-cycle strobe that latches the note and duration.
- `beat`  in  1: one-cycle beat tick.
- `generate_next_sample`  in  1: one-cycle request from the codec side (48 kHz).
- `done_with_note`  out  1: one-cycle pulse when the note ends.
- `new_sample_ready`  out  1: one-cycle pulse marking that `sample_out` has just been updated.
- `sample_out`  out  16: signed sample.

## Operation
States:
- `IDLE`: no note active.
- `PLAYING`: note active.

Registers: `note_r`[6], `beats_left`[6], `phase`[PHASE_W], `step`[PHASE_W].

Load:
- `load_new_note` in any state latches `note_r`, `beats_left <= duration_to_load`, `phase <= 0`, `step <= STEP[note_to_load]`.
- The FSM then goes to `PLAYING`.
- Load overrides any note in progress. The aborted note produces no `done_with_note`.

Beat counting (`PLAYING`, `play_enable=1`, `beat=1`, no load that cycle):
- If `beats_left <= 1`: assert `done_with_note` next cycle and go to `IDLE`.
- Otherwise: `beats_left <= beats_left - 1`.

Zero duration:
- In `PLAYING` with `beats_left == 0`: assert `done_with_note` next cycle without waiting for a beat, then go to `IDLE`.

Sample generation (`generate_next_sample=1`):
- `new_sample_ready <= 1`.
- If `PLAYING`, `play_enable=1`, and `note_r != 0`: `sample_out <= tri(phase)` and `phase <= phase + step` (wraps mod 2^PHASE_W).
- Otherwise: `sample_out <= 0` and `phase` holds.

Triangle function:
- `m = phase[19] ? ~phase[18:4] : phase[18:4]` (15-bit unsigned).
- `tri = {m, 1'b0} - 32768`, giving the range -32768..32766.

Pause (`play_enable=0`):
- Beats are ignored; `beats_left` and `phase` are frozen.
- Loads are still accepted.

Step table:
- `STEP[n] = round(440 * 2^((n-49)/12) * 2^20 / 48000)`; `STEP[0] = 0`.
- Spot values: `STEP[49] = 9612`, `STEP[37] = 4806`, `STEP[61] = 19224`.

## Timing
Reset:
- The FSM goes to `IDLE`; `note_r`, `beats_left`, `phase`, `step` = 0.
- `done_with_note = 0`, `new_sample_ready = 0`, `sample_out = 0`.
- Reset mid-note discards the note. No `done_with_note` is emitted.

Latencies:
- All outputs are registered.
- `load_new_note` at edge k → `PLAYING` from k+1.
- Last qualifying `beat` sampled at edge j → `done_with_note` high for exactly the cycle after j.
- `duration = 0`, load at edge k → `done_with_note` after edge k+1.
- `generate_next_sample` sampled at edge k → `new_sample_ready` high and new `sample_out` valid for the cycle after k. `sample_out` holds until the next request.

Simultaneous events:
- Load and beat in the same cycle: the beat is ignored.
- Load and `generate_next_sample` in the same cycle: the sample is computed from the old state, and the load's register updates take effect at the same edge.
- Beat that ends the note and `generate_next_sample` in the same cycle: the sample is produced normally and `done_with_note` still fires.
- `done_with_note` is never high for two consecutive cycles.

## Structure
Package `note_player_pkg`:
- State enum `{IDLE, PLAYING}`.
- `PHASE_W`, `SAMPLE_W`, `SAMPLE_RATE = 48000`.
- Function `note_step(note)` returning the 64-entry STEP table.

Sub-module `note_step_rom`:
- Combinational, 6-bit address → 20-bit step.
- Instantiated once; also reused by the verification model.

## Test plan
- **Reset, then load note 49 / duration 3 with `play_enable=1`, then 3 beats spaced 10 cycles apart:** `done_with_note` pulses exactly once, the cycle after the 3rd beat. The FSM is `IDLE` afterwards.
- **Note 49 playing, 4 `generate_next_sample` requests:** `sample_out` = -32768, then samples from phase 9612, 19224, 28836, checked against `tri()`. `new_sample_ready` = 1 for one cycle after each request.
- **Rest: load note 0 / duration 2, samples requested:** `sample_out = 0` throughout. `done_with_note` fires after the 2nd beat.
- **Duration 0: load note 37 / duration 0:** `done_with_note` is high 2 cycles after the load strobe, with no beat applied.
- **Pause: `play_enable=0` for 5 beats mid-note, then resume:** beats are not counted, `phase` is frozen, and samples are 0 while paused. The note ends only after the remaining beats arrive post-resume.
- **Load during a note; load coincident with beat; reset mid-note:**
  - Load during a note: no `done_with_note` for the aborted note, and `phase` restarts at 0.
  - Load coincident with a beat: the new duration is counted in full.
  - Reset mid-note: all outputs are 0 the next cycle.
